spi_master: RTL and testbench

- Single-slave SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit full-duplex transfers.
- A host-side strobe (wr or rd, qualified by active-low cs) loads a byte, shifts it out on mosi and captures miso.
- The received byte is presented on out_data at the end of the transfer.
- Sits between a local register/bus interface and one external SPI slave.

---
 rtl/spi_master.sv | 108 ++++++++++
 tb/tb_spi_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, 8-bit full duplex; 16*CLK_DIV cycles accept-to-done.
// Requests are accepted only in IDLE; strobes arriving while busy are dropped, not queued.
module spi_master #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       wr,
  input  logic       rd,
  input  logic       cs,
  output logic [7:0] out_data,
  output logic       mosi,
  input  logic       miso,
  output logic       sclk,
  output logic       busy,
  output logic       done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_tx, r_rx, r_out;
  logic [2:0]    r_cnt;
  logic [DW-1:0] r_div;
  logic          r_sclk, r_mosi, r_busy, r_done;
  logic          w_accept, w_tick, w_fall, w_last;
  logic [7:0]    w_load;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_tick   = 1'b0;
    w_fall   = 1'b0;
    w_last   = 1'b0;
    w_load   = wr ? in_data : 8'h00;
    case (r_state)
      IDLE: begin
        if (!cs && (wr || rd)) begin
          w_accept = 1'b1;
          w_next   = XFER;
        end
      end
      XFER: begin
        w_tick = (r_div == DIV_MAX);
        w_fall = w_tick && r_sclk;
        w_last = w_fall && (r_cnt == 3'd7);
        if (w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx   <= 8'h00;
      r_rx   <= 8'h00;
      r_out  <= 8'h00;
      r_cnt  <= 3'd0;
      r_div  <= '0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_tx   <= w_load;
        r_cnt  <= 3'd0;
        r_div  <= '0;
        r_mosi <= w_load[7];
        r_busy <= 1'b1;
      end else if (r_state == XFER) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) r_sclk <= ~r_sclk;
        // Falling sclk: capture miso, then present the next MOSI bit.
        if (w_fall) begin
          r_rx   <= {r_rx[6:0], miso};
          r_tx   <= {r_tx[6:0], 1'b0};
          r_mosi <= r_tx[6];
          r_cnt  <= r_cnt + 3'd1;
        end
        if (w_last) begin
          r_out  <= {r_rx[6:0], miso};
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_mosi <= 1'b0;
          r_sclk <= 1'b0;
        end
      end
    end
  end

  assign out_data = r_out;
  assign mosi     = r_mosi;
  assign sclk     = r_sclk;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=1 and 2) share host strobes and a behavioural slave.
// Expected bytes, bit sequences and durations come from the transfer rules, not the RTL structure.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       wr, rd, cs;
  logic [7:0] out1, out2;
  logic       mosi1, mosi2, miso1, miso2, sclk1, sclk2, busy1, busy2, done1, done2;

  logic       sel, loop, smiso;
  logic [7:0] m_out;
  logic       m_mosi, m_sclk, m_busy, m_done;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .wr(wr), .rd(rd), .cs(cs),
    .out_data(out1), .mosi(mosi1), .miso(miso1), .sclk(sclk1), .busy(busy1), .done(done1)
  );

  spi_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .wr(wr), .rd(rd), .cs(cs),
    .out_data(out2), .mosi(mosi2), .miso(miso2), .sclk(sclk2), .busy(busy2), .done(done2)
  );

  always_comb begin
    miso1  = loop ? mosi1 : smiso;
    miso2  = loop ? mosi2 : smiso;
    m_out  = sel ? out2  : out1;
    m_mosi = sel ? mosi2 : mosi1;
    m_sclk = sel ? sclk2 : sclk1;
    m_busy = sel ? busy2 : busy1;
    m_done = sel ? done2 : done1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy1 && !busy2) break;
    end
    chk("wait_idle", 32'(busy1 | busy2), 32'd0);
  endtask

  // One transfer on the selected instance; inject>=0 pulses a wr of 0x33 at that cycle.
  task automatic xfer(input logic s, input logic use_rd, input logic [7:0] tx,
                      input logic [7:0] sb, input logic lp, input int inject);
    logic [7:0] exp_rx, exp_mosi, mosi_seen;
    int div, busy_cnt, done_cnt, rises, bidx, last_rise, cyc;
    logic prev, mosi_any, per_ok;
    div      = s ? 2 : 1;
    exp_mosi = use_rd ? 8'h00 : tx;
    exp_rx   = lp ? exp_mosi : sb;
    wait_idle();
    sel = s; loop = lp; smiso = sb[7];
    cs = 1'b0; wr = ~use_rd; rd = use_rd; in_data = tx;
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; rd = 1'b0; in_data = 8'($urandom);
    busy_cnt = 0; done_cnt = 0; rises = 0; bidx = 0; last_rise = -1; cyc = 0;
    prev = 1'b0; mosi_any = 1'b0; per_ok = 1'b1; mosi_seen = 8'h00;
    for (int g = 0; g < 100; g++) begin
      if (m_busy) busy_cnt++;
      if (m_done) done_cnt++;
      if (m_sclk && !prev) begin
        rises++;
        mosi_seen = {mosi_seen[6:0], m_mosi};
        if (last_rise >= 0 && (cyc - last_rise) != 2 * div) per_ok = 1'b0;
        last_rise = cyc;
      end
      if (!m_sclk && prev) begin
        bidx++;
        if (bidx < 8) smiso = sb[3'(7 - bidx)];
      end
      mosi_any |= m_mosi;
      if (cyc == inject) begin
        cs = 1'b0; wr = 1'b1; in_data = 8'h33;
      end else if (cyc == inject + 1) begin
        cs = 1'b1; wr = 1'b0;
      end
      prev = m_sclk;
      if (!m_busy) break;
      @(negedge clk);
      cyc++;
    end
    chk("sclk_rises", 32'(rises), 32'd8);
    chk("mosi_bits", 32'(mosi_seen), 32'(exp_mosi));
    chk("busy_cycles", 32'(busy_cnt), 32'(16 * div));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("out_data", 32'(m_out), 32'(exp_rx));
    chk("sclk_period", 32'(per_ok), 32'd1);
    chk("sclk_end_low", 32'(m_sclk), 32'd0);
    if (use_rd) chk("rd_mosi_zero", 32'(mosi_any), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(m_done), 32'd0);
    if (inject >= 0) begin
      chk("no_restart", 32'(m_busy), 32'd0);
      chk("out_hold", 32'(m_out), 32'(exp_rx));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int toggles, bsy;
    logic pv;
    rst = 1'b1; cs = 1'b1; wr = 1'b0; rd = 1'b0; in_data = 8'h00;
    sel = 1'b0; loop = 1'b0; smiso = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sclk", 32'(sclk1), 32'd0);
    chk("rst_mosi", 32'(mosi1), 32'd0);
    chk("rst_out", 32'(out1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_sclk2", 32'(sclk2), 32'd0);
    rst = 1'b0;
    wr = 1'b1; toggles = 0; bsy = 0; pv = sclk1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sclk1 != pv || sclk2 != pv) toggles++;
      if (busy1 || busy2) bsy++;
      pv = sclk1;
    end
    wr = 1'b0;
    chk("cs_high_toggles", 32'(toggles), 32'd0);
    chk("cs_high_busy", 32'(bsy), 32'd0);

    xfer(1'b0, 1'b0, 8'hAA, 8'h00, 1'b0, -1);
    xfer(1'b0, 1'b0, 8'h91, 8'h00, 1'b1, -1);
    xfer(1'b0, 1'b0, 8'hF0, 8'h00, 1'b1, -1);
    xfer(1'b0, 1'b0, 8'h12, 8'h00, 1'b1, -1);
    xfer(1'b0, 1'b1, 8'hFF, 8'h5C, 1'b0, -1);
    xfer(1'b0, 1'b0, 8'hAA, 8'h3C, 1'b0, 5);

    wait_idle();
    sel = 1'b0; loop = 1'b1;
    cs = 1'b0; wr = 1'b1; in_data = 8'h91;
    @(negedge clk);
    cs = 1'b1; wr = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sclk", 32'(sclk1), 32'd0);
    chk("abort_mosi", 32'(mosi1), 32'd0);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_out", 32'(out1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done1), 32'd0);

    xfer(1'b1, 1'b0, 8'hF0, 8'hA5, 1'b0, -1);

    for (int k = 0; k < 8; k++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
